// File: rtl/multi_alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multi_alarm_ctrl
//  Description : Multi-channel BCD alarm controller. Stores one alarm time per
//                channel, detects matches on the 1 s tick, and runs a
//                ring / snooze / auto-timeout session for the lowest pending
//                channel. Unattended rings are recorded in a sticky missed
//                mask.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_alarm_ctrl #(
    parameter int NUM_ALARMS       = 4,
    parameter int SNOOZE_SEC       = 5,
    parameter int MAX_SNOOZE       = 3,
    parameter int RING_TIMEOUT_SEC = 30,
    localparam int IDX_W           = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  MCLK,
    input  logic                  RESET,
    input  logic                  tick_1s,
    input  logic [15:0]           cur_time,
    input  logic                  set_we,
    input  logic [IDX_W-1:0]      set_idx,
    input  logic [15:0]           set_time,
    input  logic [NUM_ALARMS-1:0] en_mask,
    input  logic                  snooze,
    input  logic                  dismiss,
    input  logic                  missed_clr,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [15:0]           rd_time,
    output logic                  ringing,
    output logic                  snoozing,
    output logic [IDX_W-1:0]      ring_idx,
    output logic                  blink,
    output logic [NUM_ALARMS-1:0] missed_mask,
    output logic                  set_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                  state_q;
    logic [15:0]             alarm_q [NUM_ALARMS];
    logic [NUM_ALARMS-1:0]   pending_q, pending_d;
    logic [NUM_ALARMS-1:0]   missed_q,  missed_d;
    logic [IDX_W-1:0]        ring_idx_q;
    logic                    ringing_q;
    logic                    snoozing_q;
    logic                    blink_q;
    logic                    set_err_q;
    logic [7:0]              ring_tmr_q;
    logic [7:0]              snz_cd_q;
    logic [3:0]              snz_cnt_q;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                    w_bcd_ok;
    logic [31:0]             w_set_idx_ext;
    logic                    w_idx_ok;
    logic                    w_set_valid;
    logic [NUM_ALARMS-1:0]   w_match;
    logic                    w_en_cur;
    logic                    w_any_pend;
    logic [IDX_W-1:0]        w_pick_idx;
    logic [NUM_ALARMS-1:0]   w_pend_clr;
    logic [7:0]              w_tmr_inc;
    logic                    w_timeout;
    logic [NUM_ALARMS-1:0]   w_miss_set;
    logic                    w_in_service;
    logic                    w_snooze_ok;

    // Write validation: each BCD digit in range and the channel exists.
    // The index is widened first so the range test stays meaningful for any
    // channel count without being folded to a constant.
    always_comb begin
        w_bcd_ok      = (set_time[15:12] <= 4'd5) && (set_time[11:8] <= 4'd9) &&
                        (set_time[7:4]   <= 4'd5) && (set_time[3:0]  <= 4'd9);
        w_set_idx_ext = 32'(set_idx);
        w_idx_ok      = (w_set_idx_ext < 32'(NUM_ALARMS));
        w_set_valid   = w_bcd_ok && w_idx_ok;
    end

    // Channel decode: matches, enable of the serviced channel, lowest pending.
    always_comb begin
        w_in_service = (state_q != ST_IDLE);
        w_match      = '0;
        w_en_cur     = 1'b0;
        w_any_pend   = |pending_q;
        w_pick_idx   = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            // A match on the channel already in service must not re-pend it.
            w_match[i] = tick_1s && en_mask[i] && (cur_time == alarm_q[i]) &&
                         !(w_in_service && (ring_idx_q == IDX_W'(i)));
            if (ring_idx_q == IDX_W'(i)) begin
                w_en_cur = en_mask[i];
            end
        end
        // Walk downward so the lowest set index is the one that sticks.
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                w_pick_idx = IDX_W'(i);
            end
        end
    end

    // Timeout detection and the pending / missed next-state values.
    always_comb begin
        w_tmr_inc   = ring_tmr_q + 8'd1;
        // Enable-drop and dismiss outrank the timeout in the same cycle.
        w_timeout   = (state_q == ST_RING) && tick_1s && w_en_cur && !dismiss &&
                      (w_tmr_inc == 8'(RING_TIMEOUT_SEC));
        w_snooze_ok = (snz_cnt_q < 4'(MAX_SNOOZE));
        w_pend_clr  = '0;
        w_miss_set  = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            w_pend_clr[i] = (state_q == ST_IDLE) && w_any_pend &&
                            (w_pick_idx == IDX_W'(i));
            w_miss_set[i] = w_timeout && (ring_idx_q == IDX_W'(i));
        end
        pending_d = (pending_q | w_match) & ~w_pend_clr;
        // A timeout landing on the same cycle as a clear keeps its bit set.
        missed_d  = (missed_q & ~{NUM_ALARMS{missed_clr}}) | w_miss_set;
    end

    // Readback mux; out-of-range selects read as zero.
    always_comb begin
        rd_time = 16'h0000;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_time = alarm_q[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Alarm time storage and the rejected-write error pulse.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alarm_q[i] <= 16'h0000;
            end
            set_err_q <= 1'b0;
        end else begin
            set_err_q <= set_we && !w_set_valid;
            if (set_we && w_set_valid) begin
                for (int i = 0; i < NUM_ALARMS; i++) begin
                    if (set_idx == IDX_W'(i)) begin
                        alarm_q[i] <= set_time;
                    end
                end
            end
        end
    end

    // Sticky pending and missed flags.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            pending_q <= '0;
            missed_q  <= '0;
        end else begin
            pending_q <= pending_d;
            missed_q  <= missed_d;
        end
    end

    // Ring session FSM with registered status outputs.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            ring_idx_q <= '0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
            blink_q    <= 1'b0;
            ring_tmr_q <= 8'd0;
            snz_cd_q   <= 8'd0;
            snz_cnt_q  <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ringing_q  <= 1'b0;
                    snoozing_q <= 1'b0;
                    blink_q    <= 1'b0;
                    snz_cnt_q  <= 4'd0;
                    if (w_any_pend) begin
                        state_q    <= ST_RING;
                        ring_idx_q <= w_pick_idx;
                        ring_tmr_q <= 8'd0;
                        ringing_q  <= 1'b1;
                        blink_q    <= 1'b1;
                    end
                end

                ST_RING: begin
                    if (!w_en_cur || dismiss || w_timeout) begin
                        state_q    <= ST_IDLE;
                        ringing_q  <= 1'b0;
                        snoozing_q <= 1'b0;
                        blink_q    <= 1'b0;
                        ring_tmr_q <= 8'd0;
                        snz_cd_q   <= 8'd0;
                        snz_cnt_q  <= 4'd0;
                    end else if (snooze && w_snooze_ok) begin
                        state_q    <= ST_SNOOZE;
                        ringing_q  <= 1'b0;
                        snoozing_q <= 1'b1;
                        blink_q    <= 1'b0;
                        snz_cnt_q  <= snz_cnt_q + 4'd1;
                        snz_cd_q   <= 8'(SNOOZE_SEC);
                    end else if (tick_1s) begin
                        blink_q    <= ~blink_q;
                        ring_tmr_q <= w_tmr_inc;
                    end
                end

                ST_SNOOZE: begin
                    if (!w_en_cur || dismiss) begin
                        state_q    <= ST_IDLE;
                        ringing_q  <= 1'b0;
                        snoozing_q <= 1'b0;
                        blink_q    <= 1'b0;
                        ring_tmr_q <= 8'd0;
                        snz_cd_q   <= 8'd0;
                        snz_cnt_q  <= 4'd0;
                    end else if (tick_1s) begin
                        if (snz_cd_q == 8'd1) begin
                            state_q    <= ST_RING;
                            ringing_q  <= 1'b1;
                            snoozing_q <= 1'b0;
                            blink_q    <= 1'b1;
                            ring_tmr_q <= 8'd0;
                            snz_cd_q   <= 8'd0;
                        end else begin
                            snz_cd_q <= snz_cd_q - 8'd1;
                        end
                    end
                end

                default: begin
                    state_q    <= ST_IDLE;
                    ringing_q  <= 1'b0;
                    snoozing_q <= 1'b0;
                    blink_q    <= 1'b0;
                end
            endcase
        end
    end

    assign ringing     = ringing_q;
    assign snoozing    = snoozing_q;
    assign ring_idx    = ring_idx_q;
    assign blink       = blink_q;
    assign missed_mask = missed_q;
    assign set_err     = set_err_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_alarm_ctrl
//  Description : Directed self-checking bench for multi_alarm_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_alarm_ctrl;

    localparam int NUM_ALARMS = 4;
    localparam int IDX_W      = 2;

    logic                  MCLK = 1'b0;
    logic                  RESET = 1'b1;
    logic                  tick_1s = 1'b0;
    logic [15:0]           cur_time = 16'h0500;
    logic                  set_we = 1'b0;
    logic [IDX_W-1:0]      set_idx = '0;
    logic [15:0]           set_time = 16'h0000;
    logic [NUM_ALARMS-1:0] en_mask = '0;
    logic                  snooze = 1'b0;
    logic                  dismiss = 1'b0;
    logic                  missed_clr = 1'b0;
    logic [IDX_W-1:0]      rd_idx = '0;
    logic [15:0]           rd_time;
    logic                  ringing;
    logic                  snoozing;
    logic [IDX_W-1:0]      ring_idx;
    logic                  blink;
    logic [NUM_ALARMS-1:0] missed_mask;
    logic                  set_err;

    int n_checks = 0;
    int n_errors = 0;

    multi_alarm_ctrl #(
        .NUM_ALARMS       (4),
        .SNOOZE_SEC       (5),
        .MAX_SNOOZE       (3),
        .RING_TIMEOUT_SEC (30)
    ) dut (
        .MCLK        (MCLK),
        .RESET       (RESET),
        .tick_1s     (tick_1s),
        .cur_time    (cur_time),
        .set_we      (set_we),
        .set_idx     (set_idx),
        .set_time    (set_time),
        .en_mask     (en_mask),
        .snooze      (snooze),
        .dismiss     (dismiss),
        .missed_clr  (missed_clr),
        .rd_idx      (rd_idx),
        .rd_time     (rd_time),
        .ringing     (ringing),
        .snoozing    (snoozing),
        .ring_idx    (ring_idx),
        .blink       (blink),
        .missed_mask (missed_mask),
        .set_err     (set_err)
    );

    always #5 MCLK = ~MCLK;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle tick; returns just after the edge that samples it.
    task automatic tick();
        tick_1s = 1'b1;
        step(1);
        tick_1s = 1'b0;
    endtask

    task automatic write_alarm(input logic [1:0] idx, input logic [15:0] t);
        set_we   = 1'b1;
        set_idx  = idx;
        set_time = t;
        step(1);
        set_we   = 1'b0;
    endtask

    task automatic pulse_dismiss();
        dismiss = 1'b1;
        step(1);
        dismiss = 1'b0;
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1;
        step(1);
        snooze = 1'b0;
    endtask

    // Match a tick on the given time, then move the clock away so no
    // further ticks re-match; returns after the edge that enters RING.
    task automatic fire(input logic [15:0] t);
        cur_time = t;
        tick();
        cur_time = 16'h0500;
        step(1);
    endtask

    initial begin
        // ---------------- Reset state ----------------
        step(2);
        check("rst_ringing",  32'(ringing),     32'h0);
        check("rst_snoozing", 32'(snoozing),    32'h0);
        check("rst_blink",    32'(blink),       32'h0);
        check("rst_set_err",  32'(set_err),     32'h0);
        check("rst_ring_idx", 32'(ring_idx),    32'h0);
        check("rst_missed",   32'(missed_mask), 32'h0);
        check("rst_rd_time",  32'(rd_time),     32'h0);
        RESET = 1'b0;
        step(1);

        // ---------------- Write and invalid write ----------------
        write_alarm(2'd2, 16'h0130);
        rd_idx = 2'd2;
        #1;
        check("wr_ok_err",   32'(set_err), 32'h0);
        check("wr_ok_rd",    32'(rd_time), 32'h0130);
        write_alarm(2'd2, 16'h0160);
        check("wr_bad_err",  32'(set_err), 32'h1);
        check("wr_bad_rd",   32'(rd_time), 32'h0130);
        step(1);
        check("wr_bad_err_pulse", 32'(set_err), 32'h0);
        write_alarm(2'd1, 16'h0A00);
        check("wr_bad_min01_err", 32'(set_err), 32'h1);

        // ---------------- Basic ring ch2, two-edge latency ----------------
        en_mask  = 4'b0100;
        cur_time = 16'h0130;
        tick();
        cur_time = 16'h0500;
        check("lat_edge1_ringing", 32'(ringing), 32'h0);
        step(1);
        check("lat_edge2_ringing", 32'(ringing),  32'h1);
        check("lat_ring_idx",      32'(ring_idx), 32'h2);
        check("lat_blink",         32'(blink),    32'h1);
        tick();
        check("blink_toggle",      32'(blink),    32'h0);
        pulse_dismiss();
        check("dismiss_ringing",   32'(ringing),  32'h0);
        check("dismiss_blink",     32'(blink),    32'h0);

        // ---------------- Snooze three times, fourth ignored ----------------
        write_alarm(2'd0, 16'h0100);
        en_mask = 4'b0001;
        fire(16'h0100);
        check("snz_ring0", 32'(ringing),  32'h1);
        check("snz_idx0",  32'(ring_idx), 32'h0);
        for (int k = 0; k < 3; k++) begin
            pulse_snooze();
            check("snz_enter_snoozing", 32'(snoozing), 32'h1);
            check("snz_enter_ringing",  32'(ringing),  32'h0);
            repeat (4) tick();
            check("snz_4ticks_snoozing", 32'(snoozing), 32'h1);
            tick();
            check("snz_5ticks_ringing",  32'(ringing),  32'h1);
            check("snz_5ticks_blink",    32'(blink),    32'h1);
        end
        pulse_snooze();
        check("snz_4th_ringing",  32'(ringing),  32'h1);
        check("snz_4th_snoozing", 32'(snoozing), 32'h0);
        pulse_dismiss();
        check("snz_dismiss", 32'(ringing), 32'h0);

        // ---------------- Timeout on ch1 ----------------
        write_alarm(2'd1, 16'h0200);
        en_mask = 4'b0010;
        fire(16'h0200);
        check("to_ring_idx", 32'(ring_idx), 32'h1);
        repeat (29) tick();
        check("to_29_ringing", 32'(ringing),     32'h1);
        check("to_29_missed",  32'(missed_mask), 32'h0);
        tick();
        check("to_30_ringing", 32'(ringing),     32'h0);
        check("to_30_missed",  32'(missed_mask), 32'h2);
        missed_clr = 1'b1;
        step(1);
        missed_clr = 1'b0;
        check("missed_clr", 32'(missed_mask), 32'h0);

        // ---------------- Simultaneous ch0 and ch3 ----------------
        write_alarm(2'd3, 16'h0100);
        en_mask = 4'b1001;
        fire(16'h0100);
        check("dual_first_idx", 32'(ring_idx), 32'h0);
        check("dual_first_rng", 32'(ringing),  32'h1);
        pulse_dismiss();
        check("dual_gap_ringing", 32'(ringing), 32'h0);
        step(1);
        check("dual_second_rng", 32'(ringing),  32'h1);
        check("dual_second_idx", 32'(ring_idx), 32'h3);
        // Dropping the serviced channel's enable ends the session quietly.
        en_mask = 4'b0001;
        step(1);
        check("en_drop_ringing", 32'(ringing),     32'h0);
        check("en_drop_missed",  32'(missed_mask), 32'h0);

        // ---------------- Reset during SNOOZE ----------------
        fire(16'h0100);
        pulse_snooze();
        check("pre_rst_snoozing", 32'(snoozing), 32'h1);
        RESET = 1'b1;
        step(1);
        check("rst_snz_snoozing", 32'(snoozing), 32'h0);
        check("rst_snz_ringing",  32'(ringing),  32'h0);
        check("rst_snz_blink",    32'(blink),    32'h0);
        check("rst_snz_idx",      32'(ring_idx), 32'h0);
        check("rst_snz_rd_time",  32'(rd_time),  32'h0);
        RESET = 1'b0;
        step(1);

        // ---------------- Snooze and dismiss together ----------------
        write_alarm(2'd0, 16'h0100);
        fire(16'h0100);
        check("sd_ringing", 32'(ringing), 32'h1);
        snooze  = 1'b1;
        dismiss = 1'b1;
        step(1);
        snooze  = 1'b0;
        dismiss = 1'b0;
        check("sd_ringing_after",  32'(ringing),  32'h0);
        check("sd_snoozing_after", 32'(snoozing), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
